rf_wb_arbiter: RTL and testbench

Write-port controller for the 32x32 register file. It owns the file's single write port (`we`/`wa`/`wd`) and drives it from one registered stage. After reset and on request, it sequences a clear of x1..x31 to zero. Outside a clear, it shares the write port between two writeback requesters, execute and memory, using valid/ready handshakes and round-robin priority. It sits between the writeback stages and the register file; the read ports are not touched.

---
 rtl/rf_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the 32x32 register file: clears x1..x31 after reset or on request,
// then round-robin arbitrates execute/memory writebacks onto a single registered write port.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_req,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_addr,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic            rr_ptr_reg, rr_ptr_next;
    logic            rf_we_reg, rf_we_next;
    logic [AW-1:0]   rf_wa_reg, rf_wa_next;
    logic [XLEN-1:0] rf_wd_reg, rf_wd_next;
    logic            init_done_reg, init_done_next;
    logic            ex_grant, mem_grant;
    logic            last_clear;

    // The clear ends on the edge that writes the highest address.
    assign last_clear = (clr_cnt_reg == {AW{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            clr_cnt_reg   <= AW'(1);
            rr_ptr_reg    <= 1'b0;
            rf_we_reg     <= 1'b0;
            rf_wa_reg     <= '0;
            rf_wd_reg     <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            rr_ptr_reg    <= rr_ptr_next;
            rf_we_reg     <= rf_we_next;
            rf_wa_reg     <= rf_wa_next;
            rf_wd_reg     <= rf_wd_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:    if (last_clear) state_next = RUN;
            RUN:     if (clear_req) state_next = INIT;
            default: state_next = INIT;
        endcase
    end

    // rr_ptr = 0 favours execute on contention, 1 favours memory.
    always_comb begin
        ex_grant  = 1'b0;
        mem_grant = 1'b0;
        if (state_reg == RUN && !clear_req) begin
            if (ex_valid && (!mem_valid || !rr_ptr_reg)) begin
                ex_grant = 1'b1;
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end
        end
    end

    always_comb begin
        clr_cnt_next   = clr_cnt_reg;
        rr_ptr_next    = rr_ptr_reg;
        rf_we_next     = 1'b0;
        rf_wa_next     = rf_wa_reg;
        rf_wd_next     = rf_wd_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            INIT: begin
                rf_we_next     = 1'b1;
                rf_wa_next     = clr_cnt_reg;
                rf_wd_next     = '0;
                clr_cnt_next   = clr_cnt_reg + AW'(1);
                init_done_next = last_clear;
            end
            RUN: begin
                init_done_next = 1'b1;
                if (clear_req) begin
                    init_done_next = 1'b0;
                    clr_cnt_next   = AW'(1);
                end else if (ex_grant) begin
                    rf_we_next  = (ex_addr != '0);
                    rf_wa_next  = ex_addr;
                    rf_wd_next  = ex_data;
                    rr_ptr_next = 1'b1;
                end else if (mem_grant) begin
                    // x0 writes still complete the handshake but never reach the file.
                    rf_we_next  = (mem_addr != '0);
                    rf_wa_next  = mem_addr;
                    rf_wd_next  = mem_data;
                    rr_ptr_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ex_ready  = ex_grant;
    assign mem_ready = mem_grant;
    assign rf_we     = rf_we_reg;
    assign rf_wa     = rf_wa_reg;
    assign rf_wd     = rf_wd_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: clear sequence, single/contended writebacks, x0 writes,
// re-clear with a pending request and reset during a clear, against a register-file model.
module tb_rf_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear_req;
    logic            ex_valid, mem_valid;
    logic            ex_ready, mem_ready;
    logic [AW-1:0]   ex_addr, mem_addr;
    logic [XLEN-1:0] ex_data, mem_data;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            init_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [XLEN-1:0] rf_model [32];
    logic            x0_written = 1'b0;

    int exp_wd [4]     = '{32'h1, 32'hA, 32'h2, 32'hB};
    int exp_ex_rdy [4] = '{1, 0, 1, 0};

    always #5 clk = ~clk;

    rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done)
    );

    // Register file: captures the registered write port, x0 hardwired to zero.
    always @(posedge clk) begin
        if (rf_we) begin
            if (rf_wa == '0) x0_written <= 1'b1;
            else rf_model[rf_wa] <= rf_wd;
        end
    end

    function automatic logic [XLEN-1:0] rf_read(input int a);
        return (a == 0) ? '0 : rf_model[a];
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_req = 1'b0;
        ex_valid = 1'b0; ex_addr = '0; ex_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        repeat (2) @(negedge clk);

        // Reset state, with requests pending to show readys stay low.
        ex_valid = 1'b1; mem_valid = 1'b1; clear_req = 1'b1;
        #1;
        check("rst_ex_ready", ex_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wa", rf_wa, 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_init_done", init_done, 0);
        rst = 1'b0;

        // Clear sequence: edge k writes x[k] = 0; requests and clear_req ignored.
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            check($sformatf("clr%0d_we", k), rf_we, 1);
            check($sformatf("clr%0d_wa", k), rf_wa, k);
            check($sformatf("clr%0d_wd", k), rf_wd, 0);
            check($sformatf("clr%0d_done", k), init_done, (k == 31) ? 1 : 0);
            if (k < 31) begin
                #1;
                check($sformatf("clr%0d_ex_ready", k), ex_ready, 0);
                check($sformatf("clr%0d_mem_ready", k), mem_ready, 0);
            end else begin
                ex_valid = 1'b0; mem_valid = 1'b0; clear_req = 1'b0;
            end
        end
        check("clr_no_x0_write", x0_written, 0);

        // Single execute writeback.
        ex_valid = 1'b1; ex_addr = 5; ex_data = 32'hDEADBEEF;
        #1;
        check("single_ex_ready", ex_ready, 1);
        check("single_mem_ready", mem_ready, 0);
        @(negedge clk);
        ex_valid = 1'b0;
        check("single_we", rf_we, 1);
        check("single_wa", rf_wa, 5);
        check("single_wd", rf_wd, 32'hDEADBEEF);
        @(negedge clk);
        check("idle_we", rf_we, 0);
        check("idle_wa_hold", rf_wa, 5);
        check("idle_wd_hold", rf_wd, 32'hDEADBEEF);
        check("x5_read", rf_read(5), 32'hDEADBEEF);

        // Memory write to x0: handshake completes, no write enable.
        mem_valid = 1'b1; mem_addr = 0; mem_data = 32'hFFFFFFFF;
        #1;
        check("x0_mem_ready", mem_ready, 1);
        check("x0_ex_ready", ex_ready, 0);
        @(negedge clk);
        mem_valid = 1'b0;
        check("x0_we", rf_we, 0);
        check("x0_wa", rf_wa, 0);
        check("x0_wd", rf_wd, 32'hFFFFFFFF);
        @(negedge clk);
        check("x0_never_written", x0_written, 0);

        // Contention on x3: grants alternate ex, mem, ex, mem.
        ex_valid = 1'b1; ex_addr = 3; ex_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 3; mem_data = 32'hA;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cont%0d_ex_ready", i), ex_ready, exp_ex_rdy[i]);
            check($sformatf("cont%0d_mem_ready", i), mem_ready, (exp_ex_rdy[i] == 1) ? 0 : 1);
            @(negedge clk);
            check($sformatf("cont%0d_we", i), rf_we, 1);
            check($sformatf("cont%0d_wa", i), rf_wa, 3);
            check($sformatf("cont%0d_wd", i), rf_wd, exp_wd[i]);
            if (exp_ex_rdy[i] == 1) ex_data = 32'h2;
            else mem_data = 32'hB;
            if (i == 3) begin
                ex_valid = 1'b0; mem_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("x3_final", rf_read(3), 32'hB);

        // Re-clear with an execute request pending.
        ex_valid = 1'b1; ex_addr = 7; ex_data = 32'h12345678; clear_req = 1'b1;
        #1;
        check("reclr_ex_ready", ex_ready, 0);
        @(negedge clk);
        clear_req = 1'b0;
        check("reclr_done_drop", init_done, 0);
        check("reclr_we", rf_we, 0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            check($sformatf("reclr%0d_we", k), rf_we, 1);
            check($sformatf("reclr%0d_wa", k), rf_wa, k);
            if (k < 31) begin
                #1;
                check($sformatf("reclr%0d_ex_ready", k), ex_ready, 0);
            end
        end
        check("reclr_done", init_done, 1);
        check("reclr_x5_read", rf_read(5), 0);
        #1;
        check("pending_ex_ready", ex_ready, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        check("pending_we", rf_we, 1);
        check("pending_wa", rf_wa, 7);
        check("pending_wd", rf_wd, 32'h12345678);
        @(negedge clk);
        check("x7_read", rf_read(7), 32'h12345678);

        // Reset in the middle of a clear, with clr_cnt at 10.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_before_wa", rf_wa, 9);
        rst = 1'b1;
        #1;
        check("midrst_we", rf_we, 0);
        check("midrst_wa", rf_wa, 0);
        check("midrst_wd", rf_wd, 0);
        check("midrst_done", init_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_we", rf_we, 1);
        check("restart_wa1", rf_wa, 1);
        @(negedge clk);
        check("restart_wa2", rf_wa, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
